// File: rtl/sram_line_packer_pkg.sv
// Shared constants and state encoding for the SRAM line packer/unpacker pair.
// Five 48-bit entries make one 240-bit pattern SRAM line.
package sram_line_packer_pkg;
  localparam int ENTRY_W = 48;
  localparam int ENTRIES = 5;
  localparam int ADDR_W  = 8;
  localparam int LINE_W  = ENTRY_W * ENTRIES;
  localparam int SLOT_W  = $clog2(ENTRIES + 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/sram_line_packer_line_assembler.sv
// Slot counter plus line buffer; entry 0 lands in the most significant slot.
// o_line_nxt is the buffer with the current load applied.
module sram_line_packer_line_assembler
  import sram_line_packer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ENTRY_W-1:0] i_data,
  output logic [SLOT_W-1:0] o_slot,
  output logic [LINE_W-1:0] o_line_nxt
);

  logic [SLOT_W-1:0] r_slot;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] w_line_nxt;

  always_comb begin
    w_line_nxt = r_line;
    if (i_load) begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (r_slot == SLOT_W'(k))
          w_line_nxt[ENTRY_W*(ENTRIES-k)-1 -: ENTRY_W] = i_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot <= '0;
      r_line <= '0;
    end else if (i_clear) begin
      r_slot <= '0;
      r_line <= '0;
    end else if (i_load) begin
      r_slot <= r_slot + 1'b1;
      r_line <= w_line_nxt;
    end
  end

  assign o_slot     = r_slot;
  assign o_line_nxt = w_line_nxt;

endmodule

// File: rtl/sram_line_packer.sv
// Packs a 48-bit entry stream into 240-bit lines and writes them to the
// pattern SRAM at a self-incrementing address until LAST_ADDR is filled.
module sram_line_packer
  import sram_line_packer_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int LAST_ADDR = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ENTRY_W-1:0] in_data,
  output logic               in_ready,
  input  logic               flush,
  input  logic               restart,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [LINE_W-1:0]  wr_data,
  output logic [ADDR_W:0]    line_count,
  output logic               done
);

  state_e            r_state;
  logic              r_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [LINE_W-1:0] r_wr_data;
  logic [ADDR_W:0]   r_count;
  logic              r_done;

  logic              w_accept;
  logic              w_clear;
  logic              w_last;
  logic              w_go;
  logic [SLOT_W-1:0] w_slot;
  logic [LINE_W-1:0] w_line_nxt;

  assign w_accept = in_valid && r_ready;
  assign w_clear  = (r_state == ST_WRITE);
  assign w_last   = (w_slot == SLOT_W'(ENTRIES - 1));
  // flush only closes a line that holds at least one entry
  assign w_go     = flush ? (w_accept || (w_slot != '0))
                          : (w_accept && w_last);

  sram_line_packer_line_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_accept),
    .i_clear    (w_clear),
    .i_data     (in_data),
    .o_slot     (w_slot),
    .o_line_nxt (w_line_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_FILL;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= ADDR_W'(BASE_ADDR);
      r_wr_data <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          r_ready <= 1'b1;
          if (w_go) begin
            r_state   <= ST_WRITE;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b1;
            r_wr_data <= w_line_nxt;
          end
        end
        ST_WRITE: begin
          r_wr_en <= 1'b0;
          r_count <= r_count + 1'b1;
          if (r_wr_addr == ADDR_W'(LAST_ADDR)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ST_FILL;
            r_ready   <= 1'b1;
            r_wr_addr <= r_wr_addr + 1'b1;
          end
        end
        ST_DONE: begin
          if (restart) begin
            r_state   <= ST_FILL;
            r_ready   <= 1'b1;
            r_wr_addr <= ADDR_W'(BASE_ADDR);
            r_count   <= '0;
            r_done    <= 1'b0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign line_count = r_count;
  assign done       = r_done;

endmodule

// File: tb/tb_sram_line_packer.sv
// Directed bench for sram_line_packer built with LAST_ADDR=2.
// Writes are captured at negedge into a queue and compared to constants.
module tb_sram_line_packer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [47:0]  in_data = '0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         restart = 1'b0;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [239:0] wr_data;
  logic [8:0]   line_count;
  logic         done;

  int checks = 0;
  int errors = 0;
  int lowcnt = 0;
  logic [247:0] wq[$];

  always #5 clock = ~clock;

  sram_line_packer #(.BASE_ADDR(0), .LAST_ADDR(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .restart    (restart),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .line_count (line_count),
    .done       (done)
  );

  always @(negedge clock) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (reset && !in_ready && !done) lowcnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [247:0] wget(input int i);
    if (i < wq.size()) return wq[i];
    return '1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; restart = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    wq.delete();
    lowcnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [47:0] d, input logic fl);
    int n;
    @(negedge clock);
    in_valid = 1'b1; in_data = d; flush = fl;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 256'd0, 256'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0; in_data = 48'hBAD0BAD0BAD0;
  endtask

  task automatic do_flush();
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
  endtask

  initial begin
    logic [47:0] ent [10];
    int idx;
    int cyc;
    int hi;
    logic will;

    // reset state
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_count", line_count, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", in_ready, 1);

    // one full line
    do_reset();
    for (int i = 1; i <= 5; i++) push(48'(i), 1'b0);
    idle(3);
    chk("t1_nwr", wq.size(), 1);
    chk("t1_line", wget(0), {8'd0, 48'h1, 48'h2, 48'h3, 48'h4, 48'h5});
    chk("t1_count", line_count, 1);
    chk("t1_lowcnt", lowcnt, 1);
    chk("t1_ready", in_ready, 1);

    // 12 entries then flush
    do_reset();
    for (int i = 1; i <= 12; i++) push(48'hA00 + 48'(i), 1'b0);
    idle(3);
    chk("t2_nwr", wq.size(), 2);
    chk("t2_lowcnt", lowcnt, 2);
    chk("t2_line0", wget(0), {8'd0, 48'hA01, 48'hA02, 48'hA03,
                              48'hA04, 48'hA05});
    chk("t2_line1", wget(1), {8'd1, 48'hA06, 48'hA07, 48'hA08,
                              48'hA09, 48'hA0A});
    do_flush();
    idle(3);
    chk("t2_nwr_fl", wq.size(), 3);
    chk("t2_line2", wget(2), {8'd2, 48'hA0B, 48'hA0C, 144'h0});
    chk("t2_count", line_count, 3);
    chk("t2_done", done, 1);

    // flush on empty, flush with accept
    do_reset();
    do_flush();
    idle(3);
    chk("t3_empty_flush", wq.size(), 0);
    push(48'hB01, 1'b0);
    push(48'hB02, 1'b0);
    push(48'hB03, 1'b1);
    idle(3);
    chk("t3_nwr", wq.size(), 1);
    chk("t3_line", wget(0), {8'd0, 48'hB01, 48'hB02, 48'hB03, 96'h0});

    // fill memory, stall in DONE, restart
    do_reset();
    for (int i = 1; i <= 15; i++) push(48'(i), 1'b0);
    idle(3);
    chk("t4_nwr", wq.size(), 3);
    chk("t4_addr2", wget(2), {8'd2, 48'd11, 48'd12, 48'd13,
                              48'd14, 48'd15});
    chk("t4_done", done, 1);
    chk("t4_ready", in_ready, 0);
    chk("t4_count", line_count, 3);
    @(negedge clock);
    in_valid = 1'b1; in_data = 48'hFFF; flush = 1'b1;
    hi = 0;
    repeat (8) begin
      @(negedge clock);
      if (in_ready || wr_en) hi++;
    end
    in_valid = 1'b0; flush = 1'b0;
    chk("t4_stall", hi, 0);
    chk("t4_nwr_stall", wq.size(), 3);
    @(negedge clock); restart = 1'b1;
    @(posedge clock); #1; restart = 1'b0;
    @(negedge clock);
    chk("t4_rs_done", done, 0);
    chk("t4_rs_count", line_count, 0);
    chk("t4_rs_ready", in_ready, 1);
    for (int i = 1; i <= 5; i++) push(48'hD00 + 48'(i), 1'b0);
    idle(3);
    chk("t4_rs_line", wget(3), {8'd0, 48'hD01, 48'hD02, 48'hD03,
                                48'hD04, 48'hD05});
    chk("t4_rs_count1", line_count, 1);

    // async reset mid-line
    do_reset();
    for (int i = 1; i <= 5; i++) push(48'(i), 1'b0);
    for (int i = 1; i <= 3; i++) push(48'hE00 + 48'(i), 1'b0);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    chk("t5_ready", in_ready, 0);
    chk("t5_count", line_count, 0);
    chk("t5_addr", wr_addr, 0);
    chk("t5_data", wr_data, 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    wq.delete();
    for (int i = 1; i <= 5; i++) push(48'hF00 + 48'(i), 1'b0);
    idle(3);
    chk("t5_nwr", wq.size(), 1);
    chk("t5_line", wget(0), {8'd0, 48'hF01, 48'hF02, 48'hF03,
                             48'hF04, 48'hF05});

    // valid toggling every other cycle
    do_reset();
    for (int i = 0; i < 10; i++) ent[i] = 48'hC01 + 48'(i);
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 200) begin
      @(negedge clock);
      in_valid = (cyc % 2 == 0);
      in_data = in_valid ? ent[idx] : 48'hDEAD;
      will = in_valid && in_ready;
      @(posedge clock);
      if (will) idx++;
      cyc++;
    end
    @(negedge clock); in_valid = 1'b0;
    chk("t6_accepted", idx, 10);
    idle(3);
    chk("t6_nwr", wq.size(), 2);
    chk("t6_line0", wget(0), {8'd0, 48'hC01, 48'hC02, 48'hC03,
                              48'hC04, 48'hC05});
    chk("t6_line1", wget(1), {8'd1, 48'hC06, 48'hC07, 48'hC08,
                              48'hC09, 48'hC0A});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_line_packer.md
Name: sram_line_packer

Overview:
Write-side counterpart to the SRAM line reader/unpacker. Accepts a stream of 48-bit entries over a valid/ready handshake and packs five entries into one 240-bit SRAM line. Writes each completed line to the pattern SRAM at a self-incrementing 8-bit address. It is the loader that fills the memory later scanned by the engine and controller.

Parameters:
ENTRY_W, 48, width of one entry
ENTRIES, 5, entries per SRAM line (line width = ENTRY_W*ENTRIES = 240)
ADDR_W, 8, SRAM address width
BASE_ADDR, 0, first line address written after reset or restart
LAST_ADDR, 255, last writable line address

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low; all state cleared while low
in_valid  input  1  entry present on in_data
in_data  input  ENTRY_W  entry to pack
in_ready  output  1  packer can accept an entry this cycle
flush  input  1  write the current partial line, zero-padded
restart  input  1  leave DONE, address back to BASE_ADDR
wr_en  output  1  one-cycle SRAM write strobe
wr_addr  output  ADDR_W  SRAM line address, valid with wr_en
wr_data  output  ENTRY_W*ENTRIES  SRAM line, valid with wr_en
line_count  output  ADDR_W+1  lines written since reset/restart
done  output  1  memory full, no further accepts

Behaviour:
- Reset (reset==0, async): state=FILL, slot=0, line buffer=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, line_count=0, done=0, in_ready=0. in_ready rises the first cycle after reset deasserts.
- Accept occurs when in_valid && in_ready at a rising edge.
- Packing: entry k of a line (k=0 first) goes to bits [ENTRY_W*(ENTRIES-k)-1 : ENTRY_W*(ENTRIES-1-k)]. The first entry is most significant and maps to the reader's output 1.
- States:
  - FILL: in_ready=1. Each accept stores the entry at slot, then slot++.
    - Accept at slot==ENTRIES-1 -> WRITE.
    - flush with slot>0 and no accept -> WRITE; unfilled slots are 0.
    - flush with an accept in the same cycle: the entry is stored first, then -> WRITE.
    - flush with slot==0 and no accept: ignored.
  - WRITE (exactly one cycle): in_ready=0; wr_en=1; wr_data=buffer; wr_addr=current address.
    - Next edge: buffer=0, slot=0, line_count++.
    - If wr_addr==LAST_ADDR -> DONE; otherwise wr_addr++ and -> FILL.
  - DONE: in_ready=0, done=1, wr_en=0; flush ignored. restart -> FILL with wr_addr=BASE_ADDR, line_count=0, done=0.
- wr_en, wr_addr and wr_data are registered. Latency: accept of the completing entry at edge N gives wr_en high from edge N to N+1.
- Throughput: ENTRIES entries per ENTRIES+1 cycles.
- restart in FILL or WRITE is ignored. Only reset aborts a partial line; buffered entries are discarded.
- No wrap-around. Writing past LAST_ADDR is impossible.
- in_data is ignored unless an accept occurs.

Decomposition:
- Shared package holds: ENTRY_W, ENTRIES, ADDR_W, the line width constant, and the state encoding (FILL, WRITE, DONE). The unpacking engine uses the same constants.
- One natural sub-module, line_assembler: slot counter plus line buffer with load/clear. The top holds the FSM and the address and count logic.

Test Plan:
- Reset, then 5 accepts 48'h1, 48'h2, 48'h3, 48'h4, 48'h5 back-to-back -> one wr_en pulse with wr_addr=0, wr_data={48'h1,48'h2,48'h3,48'h4,48'h5}, line_count=1; in_ready low only during the WRITE cycle.
- 12 continuous valid entries -> writes at addr 0 and 1, in_ready=0 for exactly one cycle after entries 5 and 10, 2 entries held; then flush -> addr 2 line = {e11, e12, 144'h0}.
- flush with slot==0 -> no wr_en. flush together with the 3rd accept -> line {e1, e2, e3, 96'h0}.
- LAST_ADDR=2, stream 15 entries -> writes at 0, 1, 2, then done=1, in_ready=0; entries 16+ stall. restart -> next line written at addr 0, line_count restarts at 0.
- reset pulsed low after 3 accepts -> outputs return to reset values immediately. The next 5 entries form a clean line at addr 0 with no stale data.
- in_valid toggled every other cycle, including during WRITE -> no entry lost or duplicated; line contents match the accepted order.
